// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_BLK_W = 4;

  function automatic int unsigned num_blocks(input int unsigned width);
    return width / CLA_BLK_W;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result bundle for cla_adder_pipe; results are registered by the adder.
interface cla_adder_pipe_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             out_valid;
  logic             grp_g;
  logic             grp_p;

  modport master (
    output in_valid, A, B, cin,
    input  S, cout, out_valid, grp_g, grp_p
  );

  modport slave (
    input  in_valid, A, B, cin,
    output S, cout, out_valid, grp_g, grp_p
  );
endinterface

// File: rtl/cla4_block.sv
// 4-bit carry-lookahead block: expanded-equation carries plus group generate/propagate.
module cla4_block
  import cla_pkg::*;
(
  input  logic [CLA_BLK_W-1:0] a,
  input  logic [CLA_BLK_W-1:0] b,
  input  logic                 c_in,
  output logic [CLA_BLK_W-1:0] s,
  output logic                 blk_g,
  output logic                 blk_p
);

  logic [CLA_BLK_W-1:0] g;
  logic [CLA_BLK_W-1:0] p;
  logic [CLA_BLK_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead carries; no carry ripples between bit positions.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

  assign s = p ^ c;

  assign blk_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign blk_p = &p;

endmodule

// File: rtl/cla_adder_pipe.sv
// WIDTH-bit carry-lookahead adder from 4-bit blocks with a second-level lookahead
// and a one-cycle registered result.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  cla_adder_pipe_if.slave  bus
);

  localparam int unsigned NB = num_blocks(WIDTH);

  if ((WIDTH == 0) || ((WIDTH % CLA_BLK_W) != 0)) begin : g_width_chk
    $error("cla_adder_pipe: WIDTH must be a positive multiple of 4");
  end

  logic [NB-1:0]    blk_g;
  logic [NB-1:0]    blk_p;
  logic [NB:0]      blk_c;
  logic [WIDTH-1:0] sum_c;
  logic             word_g_c;
  logic             word_p_c;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla4_block u_blk (
      .a     (bus.A[k*CLA_BLK_W +: CLA_BLK_W]),
      .b     (bus.B[k*CLA_BLK_W +: CLA_BLK_W]),
      .c_in  (blk_c[k]),
      .s     (sum_c[k*CLA_BLK_W +: CLA_BLK_W]),
      .blk_g (blk_g[k]),
      .blk_p (blk_p[k])
    );
  end

  // Second-level lookahead: block carry-ins and whole-word generate/propagate.
  always_comb begin
    blk_c    = '0;
    word_g_c = 1'b0;
    word_p_c = 1'b1;
    blk_c[0] = bus.cin;
    for (int unsigned k = 0; k < NB; k++) begin
      blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
      word_g_c   = blk_g[k] | (blk_p[k] & word_g_c);
      word_p_c   = word_p_c & blk_p[k];
    end
  end

  // Result registers load only on accepted operands so idle inputs cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.S         <= '0;
      bus.cout      <= 1'b0;
      bus.grp_g     <= 1'b0;
      bus.grp_p     <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.S     <= sum_c;
        bus.cout  <= blk_c[NB];
        bus.grp_g <= word_g_c;
        bus.grp_p <= word_p_c;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe at WIDTH=4 and WIDTH=16.
module tb_cla_adder_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        g;
    logic        p;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       g;
    logic       p;
  } vec_t;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  exp_t q4[$];
  exp_t q16[$];
  exp_t held4;
  exp_t held16;

  cla_adder_pipe_if #(.WIDTH(4))  bus4 ();
  cla_adder_pipe_if #(.WIDTH(16)) bus16 ();

  cla_adder_pipe #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  cla_adder_pipe #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] t;
    logic [4:0] t0;
    exp_t e;
    t  = 5'(a) + 5'(b) + 5'(c);
    t0 = 5'(a) + 5'(b);
    e.s    = 16'(t[3:0]);
    e.cout = t[4];
    e.g    = t0[4];
    e.p    = &(a ^ b);
    return e;
  endfunction

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t;
    logic [16:0] t0;
    exp_t e;
    t  = 17'(a) + 17'(b) + 17'(c);
    t0 = 17'(a) + 17'(b);
    e.s    = t[15:0];
    e.cout = t[16];
    e.g    = t0[16];
    e.p    = &(a ^ b);
    return e;
  endfunction

  // Drive one cycle on the 4-bit adder at negedge; check the registered result after the edge.
  task automatic cycle4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic use_want, input exp_t want);
    exp_t e;
    bus4.in_valid = v;
    bus4.A        = a;
    bus4.B        = b;
    bus4.cin      = c;
    if (v) q4.push_back(use_want ? want : model4(a, b, c));
    @(posedge clk);
    #1;
    check("out_valid4", 17'(bus4.out_valid), 17'(v));
    if (v) begin
      if (q4.size() == 0) check("q4_empty", 17'd1, 17'd0);
      else begin
        e = q4.pop_front();
        held4 = e;
      end
    end
    check("S4", 17'(bus4.S), 17'(held4.s[3:0]));
    check("cout4", 17'(bus4.cout), 17'(held4.cout));
    check("grp_g4", 17'(bus4.grp_g), 17'(held4.g));
    check("grp_p4", 17'(bus4.grp_p), 17'(held4.p));
    @(negedge clk);
  endtask

  task automatic cycle16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic use_want, input exp_t want);
    exp_t e;
    bus16.in_valid = v;
    bus16.A        = a;
    bus16.B        = b;
    bus16.cin      = c;
    if (v) q16.push_back(use_want ? want : model16(a, b, c));
    @(posedge clk);
    #1;
    check("out_valid16", 17'(bus16.out_valid), 17'(v));
    if (v) begin
      if (q16.size() == 0) check("q16_empty", 17'd1, 17'd0);
      else begin
        e = q16.pop_front();
        held16 = e;
      end
    end
    check("S16", 17'(bus16.S), 17'(held16.s));
    check("cout16", 17'(bus16.cout), 17'(held16.cout));
    check("grp_g16", 17'(bus16.grp_g), 17'(held16.g));
    check("grp_p16", 17'(bus16.grp_p), 17'(held16.p));
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_S4"}, 17'(bus4.S), 17'd0);
    check({tag, "_cout4"}, 17'(bus4.cout), 17'd0);
    check({tag, "_g4"}, 17'(bus4.grp_g), 17'd0);
    check({tag, "_p4"}, 17'(bus4.grp_p), 17'd0);
    check({tag, "_ov4"}, 17'(bus4.out_valid), 17'd0);
    check({tag, "_S16"}, 17'(bus16.S), 17'd0);
    check({tag, "_ov16"}, 17'(bus16.out_valid), 17'd0);
  endtask

  initial begin
    vec_t tab[9];
    exp_t nw;
    exp_t w;
    passed = 0;
    total  = 0;
    nw     = '0;
    held4  = '0;
    held16 = '0;

    // {a, b, cin, s, cout, grp_g, grp_p}
    tab[0] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
    tab[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};
    tab[2] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0};
    tab[3] = '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    tab[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};
    tab[5] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
    tab[6] = '{4'h5, 4'h5, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0};
    tab[7] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0};
    tab[8] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus4.in_valid = 1'b0;  bus4.A = '0;  bus4.B = '0;  bus4.cin = 1'b0;
    bus16.in_valid = 1'b0; bus16.A = '0; bus16.B = '0; bus16.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed table, applied back-to-back
    foreach (tab[i]) begin
      w = '{s: 16'(tab[i].s), cout: tab[i].cout, g: tab[i].g, p: tab[i].p};
      cycle4(1'b1, tab[i].a, tab[i].b, tab[i].cin, 1'b1, w);
    end

    // Hold: result 7 must survive an idle cycle with new and unknown operands
    cycle4(1'b1, 4'd3, 4'd4, 1'b0, 1'b1, '{s: 16'd7, cout: 1'b0, g: 1'b0, p: 1'b0});
    cycle4(1'b0, 4'd9, 4'd4, 1'b0, 1'b0, nw);
    cycle4(1'b0, 4'bxxxx, 4'bxxxx, 1'bx, 1'b0, nw);

    // Exhaustive WIDTH=4
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          cycle4(1'b1, 4'(a), 4'(b), 1'(c), 1'b0, nw);

    // Async reset: result A/1 visible, then reset between edges clears at once
    cycle4(1'b1, 4'hF, 4'hB, 1'b0, 1'b1, '{s: 16'hA, cout: 1'b1, g: 1'b1, p: 1'b0});
    cycle16(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, nw);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    // An operand presented while reset is held is discarded
    bus4.in_valid = 1'b1; bus4.A = 4'h1; bus4.B = 4'h1; bus4.cin = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
    rst_n = 1'b1;
    q4.delete();
    q16.delete();
    held4  = '0;
    held16 = '0;
    cycle4(1'b0, 4'h1, 4'h1, 1'b0, 1'b0, nw);
    cycle4(1'b1, 4'h2, 4'h3, 1'b0, 1'b1, '{s: 16'h5, cout: 1'b0, g: 1'b0, p: 1'b0});

    // WIDTH=16 directed and random
    cycle16(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, '{s: 16'h0, cout: 1'b1, g: 1'b0, p: 1'b1});
    cycle16(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, '{s: 16'h0, cout: 1'b1, g: 1'b1, p: 1'b0});
    cycle16(1'b1, 16'h0FFF, 16'h0001, 1'b0, 1'b1, '{s: 16'h1000, cout: 1'b0, g: 1'b0, p: 1'b0});
    for (int i = 0; i < 1000; i++)
      cycle16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, nw);
    cycle16(1'b0, 16'hxxxx, 16'h1111, 1'b1, 1'b0, nw);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
